alu_wb_buffer: RTL and testbench



---
 rtl/alu_wb_buffer.sv | 111 +++++++++++
 tb/tb_alu_wb_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// In-order writeback buffer between the ALU and the register file, with zero/negative flags.
// Optional macro ALU_WB_FWD_EN adds a combinational forwarding lookup over occupied entries.
module alu_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_result,
  input  logic        [REG_AW-1:0]   in_rd,
  input  logic                       in_we,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_result,
  output logic        [REG_AW-1:0]   out_rd,
  output logic                       out_we,
  output logic                       out_zero,
  output logic                       out_neg,
`ifdef ALU_WB_FWD_EN
  input  logic        [REG_AW-1:0]   fwd_rs,
  output logic                       fwd_hit,
  output logic signed [DATA_W-1:0]   fwd_data,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic signed [DATA_W-1:0] r_res  [DEPTH];
  logic        [REG_AW-1:0] r_rd   [DEPTH];
  logic                     r_we   [DEPTH];
  logic                     r_zero [DEPTH];
  logic                     r_neg  [DEPTH];
  logic        [PW-1:0]     r_wptr;
  logic        [PW-1:0]     r_rptr;
  logic        [CW-1:0]     r_count;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count != CNT_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_result = r_res[r_rptr];
  assign out_rd     = r_rd[r_rptr];
  assign out_we     = r_we[r_rptr];
  assign out_zero   = r_zero[r_rptr];
  assign out_neg    = r_neg[r_rptr];
  assign count      = r_count;

  // Flags are resolved at push so the head entry drives outputs straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i]  <= '0;
        r_rd[i]   <= '0;
        r_we[i]   <= 1'b0;
        r_zero[i] <= 1'b0;
        r_neg[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_res[r_wptr]  <= in_result;
        r_rd[r_wptr]   <= in_rd;
        r_we[r_wptr]   <= in_we & (in_rd != '0);
        r_zero[r_wptr] <= (in_result == '0);
        r_neg[r_wptr]  <= in_result[DATA_W-1];
        r_wptr         <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

`ifdef ALU_WB_FWD_EN
  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so the most recently pushed match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = r_rptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if ((CW'(i) < r_count) && r_we[w_idx] && (r_rd[w_idx] == fwd_rs) && (fwd_rs != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_res[w_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: stimulus queues expected entries, a monitor checks each pop.
module tb_alu_wb_buffer;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_result;
  logic        [4:0]  in_rd;
  logic               in_we;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_result;
  logic        [4:0]  out_rd;
  logic               out_we;
  logic               out_zero;
  logic               out_neg;
  logic        [1:0]  count;
`ifdef ALU_WB_FWD_EN
  logic        [4:0]  fwd_rs;
  logic               fwd_hit;
  logic signed [31:0] fwd_data;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb[$];

  alu_wb_buffer #(.DATA_W(32), .REG_AW(5), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
`ifdef ALU_WB_FWD_EN
    .fwd_rs     (fwd_rs),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
`endif
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready hold mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_result=%h required=none", out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_result", out_result, e.res);
        chk("pop_rd",     {27'b0, out_rd}, {27'b0, e.rd});
        chk("pop_we",     {31'b0, out_we}, {31'b0, e.we});
        chk("pop_zero",   {31'b0, out_zero}, {31'b0, e.z});
        chk("pop_neg",    {31'b0, out_neg}, {31'b0, e.n});
      end
    end
  end

  // Expected flags come from the caller's hand-computed vector, not from the inputs.
  task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic we,
                      input logic ewe, input logic ez, input logic en);
    exp_t e;
    in_valid  = 1'b1;
    in_result = res;
    in_rd     = rd;
    in_we     = we;
    e.res = res; e.rd = rd; e.we = ewe; e.z = ez; e.n = en;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_rd     = '0;
    in_we     = 1'b0;
    out_ready = 1'b0;
`ifdef ALU_WB_FWD_EN
    fwd_rs    = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",   {31'b0, in_ready}, 32'd1);
    chk("rst_count",      {30'b0, count}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd",     {27'b0, out_rd}, 32'd0);
    chk("rst_out_flags",  {29'b0, out_we, out_zero, out_neg}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, one-cycle latency
    push(32'h0000_0005, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_out_valid",  {31'b0, out_valid}, 32'd1);
    chk("t1_out_result", out_result, 32'd5);
    chk("t1_out_rd",     {27'b0, out_rd}, 32'd3);
    chk("t1_flags",      {29'b0, out_we, out_zero, out_neg}, 32'b100);
    chk("t1_count",      {30'b0, count}, 32'd1);
    @(posedge clk);
    #1;
    chk("t1_hold_result", out_result, 32'd5);
    pop_n(1);
    chk("t1_empty", {31'b0, out_valid}, 32'd0);

    // Fill to full, then drain
    push(32'hFFFF_FFF0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    push(32'h0000_0000, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_count_full", {30'b0, count}, 32'd2);
    chk("t2_in_ready",   {31'b0, in_ready}, 32'd0);
    pop_n(2);
    chk("t2_count_empty", {30'b0, count}, 32'd0);
    chk("t2_in_ready_e",  {31'b0, in_ready}, 32'd1);

    // Write-enable suppression
    push(32'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'd7, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_n(2);

    // Steady push+pop at count=1
    push(32'd100, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      exp_t e;
      in_valid  = 1'b1;
      in_result = k;
      in_rd     = 5'(k + 10);
      in_we     = 1'b1;
      out_ready = 1'b1;
      e.res = k; e.rd = 5'(k + 10); e.we = 1'b1; e.z = 1'b0; e.n = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk("t4_count", {30'b0, count}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    pop_n(1);
    chk("t4_drained", {30'b0, count}, 32'd0);

    // Asynchronous flush mid-cycle
    push(32'h1234_5678, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    push(32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_count",     {30'b0, count}, 32'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_in_ready",   {31'b0, in_ready}, 32'd1);
    chk("t5_out_valid2", {31'b0, out_valid}, 32'd0);

`ifdef ALU_WB_FWD_EN
    // Forwarding picks the youngest matching entry
    push(32'h0000_AAAA, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    push(32'h0000_BBBB, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    fwd_rs = 5'd4;
    #1;
    chk("t6_hit",  {31'b0, fwd_hit}, 32'd1);
    chk("t6_data", fwd_data, 32'h0000_BBBB);
    pop_n(1);
    chk("t6_hit_pop",  {31'b0, fwd_hit}, 32'd1);
    chk("t6_data_pop", fwd_data, 32'h0000_BBBB);
    fwd_rs = 5'd0;
    #1;
    chk("t6_rs0_hit",  {31'b0, fwd_hit}, 32'd0);
    chk("t6_rs0_data", fwd_data, 32'd0);
    pop_n(1);
    fwd_rs = 5'd4;
    #1;
    chk("t6_empty_hit", {31'b0, fwd_hit}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
